// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding
// and default bus geometry / ack timeout.
package wb_pkg;

  localparam int WB_AW_DEF      = 32;
  localparam int WB_DW_DEF      = 32;
  localparam int WB_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } wb_mst_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack-wait counter for the Wishbone command master. expired_o flags the
// BUS cycle in which the count would reach TIMEOUT, so the master can leave
// BUS on that same edge. Width is clog2(TIMEOUT+1); the master leaves BUS
// before the count could pass TIMEOUT, so it never wraps.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear outside BUS, advance on each BUS cycle without ack
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master driven by a valid/ready command
// port, returning a valid/ready response. One transfer at a time, with a
// forced idle GAP cycle so stb always shows a rising edge.
// Optional ack timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN; without
// it BUS waits for ack indefinitely and rsp_err_o is never set.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW_DEF,
  parameter int DW      = WB_DW_DEF,
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  wb_mst_state_t   state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_reset_ni),
    .clr_i     (state_q != ST_BUS),
    .en_i      ((state_q == ST_BUS) && !wb_ack_i),
    .expired_o (timeout_hit)
  );
`else
  // No counter: the only way out of BUS is an ack, so rsp_err stays 0
  assign timeout_hit = 1'b0;
`endif

  // Next-state and register updates; ack takes priority over timeout
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          rsp_dat_d = we_q ? '0 : wb_dat_i;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (timeout_hit) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the async reset
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign wb_cyc_o    = (state_q == ST_BUS);
  assign wb_stb_o    = (state_q == ST_BUS);
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter AW, default 32, Wishbone address width.
REQ-002 Parameter DW, default 32, Wishbone data width; multiple of 8.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles waiting for ack; range 1..65535.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 wb_reset_ni  in  1  asynchronous active-low reset.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  command accepted when valid and ready are both high.
REQ-009 cmd_we_i  in  1  1 = write, 0 = read.
REQ-010 cmd_adr_i  in  AW  target address.
REQ-011 cmd_dat_i  in  DW  write data.
REQ-012 cmd_sel_i  in  DW/8  byte selects.
REQ-013 rsp_valid_o  out  1  response available.
REQ-014 rsp_ready_i  in  1  response consumed when valid and ready are both high.
REQ-015 rsp_dat_o  out  DW  read data; 0 for writes and timeouts.
REQ-016 rsp_err_o  out  1  transaction timed out.
REQ-017 wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  out  AW/DW/DW/8/1/1/1  Wishbone classic master outputs.
REQ-018 wb_dat_i  in  DW, wb_ack_i  in  1  Wishbone slave returns.

Function
REQ-019 FSM states: IDLE, BUS, RESP, GAP.
REQ-020 IDLE: cmd_ready_o = 1; on handshake, latch we/adr/dat/sel into wb_* outputs and enter BUS on the next cycle.
REQ-021 BUS: wb_cyc_o = wb_stb_o = 1; outputs held stable; cmd_ready_o = 0.
REQ-022 BUS, wb_ack_i = 1: capture wb_dat_i when read (0 when write), rsp_err_o = 0, drop cyc/stb in the same edge, enter RESP.
REQ-023 BUS timeout counter: cleared on entry, incremented each BUS cycle without ack; counter reaching TIMEOUT drops cyc/stb, sets rsp_err_o = 1, rsp_dat_o = 0, enters RESP.
REQ-024 Ack on the same cycle the counter reaches TIMEOUT: the ack wins, rsp_err_o = 0.
REQ-025 wb_ack_i outside BUS is ignored.
REQ-026 RESP: rsp_valid_o = 1 with dat/err stable until rsp_ready_i; on handshake enter GAP.
REQ-027 GAP: exactly one cycle with cyc/stb low, then IDLE. This guarantees a stb rising edge for edge-detecting slaves.
REQ-028 Minimum command-to-command spacing: BUS(>=1) + RESP(>=1) + GAP(1) + IDLE(1) cycles; no back-to-back stb.
REQ-029 cmd_ready_o is combinational from state only and does not depend on cmd_valid_i.
REQ-030 Counter width is clog2(TIMEOUT+1); no wrap is possible.

Reset
REQ-031 Asserting wb_reset_ni low at any time, including mid-BUS, immediately forces IDLE with cyc/stb/we low; adr/dat/sel = 0; rsp_valid_o = 0; rsp_dat_o = 0; rsp_err_o = 0; counter = 0. An in-flight transaction is abandoned without a response.
REQ-032 After deassertion, cmd_ready_o = 1 on the first clock.

Configuration
REQ-033 Macro WB_CMD_MASTER_TIMEOUT_EN defined: timeout per REQ-023/024 is active.
REQ-034 Macro undefined: no counter is built, BUS waits for ack indefinitely, and rsp_err_o is tied 0.

Structure
REQ-035 Shared package wb_pkg holds the FSM state enum (wb_mst_state_t) and default AW/DW/TIMEOUT constants.
REQ-036 One sub-module, wb_timeout_ctr (clear, enable, expired flag), instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

Verification
REQ-037 Write cmd adr=0x0, dat=0x5A, sel=0x1, slave acks on the 2nd BUS cycle -> one cyc/stb pulse of 2 cycles, we=1, rsp_valid with err=0, dat=0.
REQ-038 Read adr=0x4, slave returns 0xFFFF8001 with ack -> rsp_dat_o=0xFFFF8001, err=0.
REQ-039 TIMEOUT=8, slave never acks -> cyc/stb drop after 8 BUS cycles, rsp_err_o=1, rsp_dat_o=0; with the macro undefined, cyc held for 100 cycles and no response.
REQ-040 Ack on exactly the TIMEOUT cycle -> err=0, data captured.
REQ-041 Two back-to-back commands with rsp_ready held high -> stb low for >=2 cycles between them; rsp_ready held low for 5 cycles -> rsp stable, cmd_ready_o=0.
REQ-042 Reset pulse mid-BUS -> cyc/stb low asynchronously, no rsp_valid, next command completes normally.
